// File: rtl/hiaddr_remap_pkg.sv
// Shared constants and types for the 65816 high-address remap / host-access controller.
// Register offsets, ctrl bit positions, wait-FSM states and fixed addresses live here.
package hiaddr_remap_pkg;

    localparam logic [3:0] OFF_CTRL     = 4'd0;
    localparam logic [3:0] OFF_STATUS   = 4'd1;
    localparam logic [3:0] OFF_ROM_SLOT = 4'd2;
    localparam logic [3:0] OFF_ROM_TGT  = 4'd3;
    localparam int         OFF_WIN_BASE = 4;

    localparam int CTRL_ROM_EN   = 5;
    localparam int CTRL_BLOCK_WR = 6;
    localparam int CTRL_WAIT_EN  = 7;
    // ctrl bit 4 is reserved and always reads back as zero.
    localparam logic [7:0] CTRL_WR_MASK = 8'hEF;

    localparam int WIN_EN_BIT = 7;

    localparam logic [15:0] PAGEREG_ADDR = 16'hFE30;
    localparam logic [7:0]  BOOT_TGT     = 8'hFE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } wait_state_e;

endpackage

// File: rtl/host_wait_fsm_m.sv
// Host-cycle wait-state handshake: stalls the CPU while the host bus completes,
// with a bounded wait and a one-cycle timeout pulse for the sticky status bit.
module host_wait_fsm_m
    import hiaddr_remap_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic resetb,
    input  logic hit,
    input  logic host_ack,
    output logic rdy_o,
    output logic host_req,
    output logic timeout_pulse
);

    localparam int              CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    wait_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rdy_o         = 1'b1;
        host_req      = 1'b0;
        timeout_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The stall must take effect in the very cycle the host access appears.
                if (hit) begin
                    rdy_o    = 1'b0;
                    host_req = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                rdy_o    = 1'b0;
                host_req = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (host_ack) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_pulse = 1'b1;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/hiaddr_remap_ctrl.sv
// Memory-map and host-access controller: resolves each 24-bit bus cycle to RAM,
// host bus or the internal register file, and owns the remap/shadow registers.
module hiaddr_remap_ctrl
    import hiaddr_remap_pkg::*;
#(
    parameter int         NWIN      = 4,
    parameter int         RAM_AW    = 19,
    parameter int         PAGEREG_W = 4,
    parameter logic [7:0] REG_BANK  = 8'hBF,
    parameter int         TIMEOUT   = 15,
    parameter int         BOOT_MAP  = 1
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic [7:0]           bank,
    input  logic [15:0]          addr,
    input  logic                 rnw,
    input  logic                 vda,
    input  logic                 vpa,
    input  logic                 vpb,
    input  logic                 cpu_e,
    input  logic [7:0]           wdata,
    input  logic                 hs_active,
    input  logic                 host_ack,
    output logic                 ram_ceb,
    output logic [RAM_AW-17:0]   ram_bank,
    output logic                 host_sel,
    output logic                 host_req,
    output logic                 host_wr_ok,
    output logic                 rdy_o,
    output logic                 reg_sel,
    output logic [7:0]           reg_rdata,
    output logic [3:0]           clk_cfg
);

    logic                        valid;
    logic                        win_hit;
    logic                        reg_wr;
    logic                        hit;
    logic                        timeout_pulse;
    logic [7:0]                  eb;
    logic [7:0]                  rdata;

    logic [7:0]                  ctrl_q, ctrl_d;
    logic                        timeout_q, timeout_d;
    logic [PAGEREG_W-1:0]        rom_slot_q, rom_slot_d;
    logic [PAGEREG_W-1:0]        pagereg_q, pagereg_d;
    logic [7:0]                  rom_tgt_q, rom_tgt_d;
    logic [NWIN-1:0]             win_en_q, win_en_d;
    logic [NWIN-1:0][1:0]        win_region_q, win_region_d;
    logic [NWIN-1:0][7:0]        win_tgt_q, win_tgt_d;

    // Effective-bank resolution; earlier rules take priority over later ones.
    always_comb begin
        valid   = vda | vpa;
        reg_sel = 1'b0;
        win_hit = 1'b0;
        eb      = bank;
        if (!vpb && !cpu_e) begin
            eb = 8'hFF;
        end else if (bank == REG_BANK) begin
            reg_sel = 1'b1;
        end else if (bank == 8'h00) begin
            // Scanning downwards leaves the lowest-index matching window in eb.
            for (int i = NWIN - 1; i >= 0; i--) begin
                if (win_en_q[i] && (win_region_q[i] == addr[15:14])) begin
                    win_hit = 1'b1;
                    eb      = win_tgt_q[i];
                end
            end
            if (!win_hit && (addr[15:14] == 2'b10) && ctrl_q[CTRL_ROM_EN] &&
                (pagereg_q == rom_slot_q)) begin
                eb = rom_tgt_q;
            end
        end
        ram_ceb    = !(valid && (eb[7:6] == 2'b11) && !reg_sel);
        ram_bank   = eb[RAM_AW-17:0];
        host_sel   = valid && !eb[7];
        host_wr_ok = !(ctrl_q[CTRL_BLOCK_WR] && !addr[15]);
        clk_cfg    = ctrl_q[3:0];
        hit        = host_sel && hs_active && ctrl_q[CTRL_WAIT_EN];
        reg_wr     = reg_sel && !rnw && vda && rdy_o;
    end

    always_comb begin
        rdata = 8'h00;
        case (addr[3:0])
            OFF_CTRL:     rdata = ctrl_q;
            OFF_STATUS:   rdata = {7'b0, timeout_q};
            OFF_ROM_SLOT: rdata[PAGEREG_W-1:0] = rom_slot_q;
            OFF_ROM_TGT:  rdata = rom_tgt_q;
            default: begin
                for (int i = 0; i < NWIN; i++) begin
                    if (int'(addr[3:0]) == OFF_WIN_BASE + 2 * i)
                        rdata = {win_en_q[i], 5'b0, win_region_q[i]};
                    if (int'(addr[3:0]) == OFF_WIN_BASE + 2 * i + 1)
                        rdata = win_tgt_q[i];
                end
            end
        endcase
        reg_rdata = reg_sel ? rdata : 8'h00;
    end

    always_comb begin
        ctrl_d       = ctrl_q;
        timeout_d    = timeout_q;
        rom_slot_d   = rom_slot_q;
        rom_tgt_d    = rom_tgt_q;
        win_en_d     = win_en_q;
        win_region_d = win_region_q;
        win_tgt_d    = win_tgt_q;
        pagereg_d    = pagereg_q;
        if (reg_wr) begin
            case (addr[3:0])
                OFF_CTRL:     ctrl_d = wdata & CTRL_WR_MASK;
                OFF_STATUS:   if (wdata[0]) timeout_d = 1'b0;
                OFF_ROM_SLOT: rom_slot_d = wdata[PAGEREG_W-1:0];
                OFF_ROM_TGT:  rom_tgt_d = wdata;
                default: begin
                    for (int i = 0; i < NWIN; i++) begin
                        if (int'(addr[3:0]) == OFF_WIN_BASE + 2 * i) begin
                            win_en_d[i]     = wdata[WIN_EN_BIT];
                            win_region_d[i] = wdata[1:0];
                        end
                        if (int'(addr[3:0]) == OFF_WIN_BASE + 2 * i + 1)
                            win_tgt_d[i] = wdata;
                    end
                end
            endcase
        end
        if (timeout_pulse) timeout_d = 1'b1;
        // Snoops the host's ROM-select latch so the shadow follows paged-ROM switches.
        if (valid && !rnw && (eb == 8'h00) && (addr == PAGEREG_ADDR))
            pagereg_d = wdata[PAGEREG_W-1:0];
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ctrl_q     <= 8'h00;
            timeout_q  <= 1'b0;
            rom_slot_q <= '0;
            rom_tgt_q  <= 8'h00;
            pagereg_q  <= '0;
            for (int i = 0; i < NWIN; i++) begin
                win_en_q[i]     <= (BOOT_MAP != 0) && (i < 2);
                win_region_q[i] <= ((BOOT_MAP != 0) && (i == 1)) ? 2'd1 : 2'd0;
                win_tgt_q[i]    <= ((BOOT_MAP != 0) && (i < 2)) ? BOOT_TGT : 8'h00;
            end
        end else begin
            ctrl_q       <= ctrl_d;
            timeout_q    <= timeout_d;
            rom_slot_q   <= rom_slot_d;
            rom_tgt_q    <= rom_tgt_d;
            pagereg_q    <= pagereg_d;
            win_en_q     <= win_en_d;
            win_region_q <= win_region_d;
            win_tgt_q    <= win_tgt_d;
        end
    end

    host_wait_fsm_m #(
        .TIMEOUT(TIMEOUT)
    ) u_wait (
        .clk           (clk),
        .resetb        (resetb),
        .hit           (hit),
        .host_ack      (host_ack),
        .rdy_o         (rdy_o),
        .host_req      (host_req),
        .timeout_pulse (timeout_pulse)
    );

endmodule

// File: tb/tb_hiaddr_remap_ctrl.sv
// Bench for hiaddr_remap_ctrl: directed scenarios plus random bus traffic, all
// checked every cycle against a register-image model of the address map.
module tb_hiaddr_remap_ctrl;

    localparam int NWIN    = 4;
    localparam int TIMEOUT = 15;

    logic        clk, resetb;
    logic [7:0]  bank;
    logic [15:0] addr;
    logic        rnw, vda, vpa, vpb, cpu_e;
    logic [7:0]  wdata;
    logic        hs_active, host_ack;
    logic        ram_ceb;
    logic [2:0]  ram_bank;
    logic        host_sel, host_req, host_wr_ok, rdy_o, reg_sel;
    logic [7:0]  reg_rdata;
    logic [3:0]  clk_cfg;

    hiaddr_remap_ctrl #(
        .NWIN(NWIN), .RAM_AW(19), .PAGEREG_W(4), .REG_BANK(8'hBF),
        .TIMEOUT(TIMEOUT), .BOOT_MAP(1)
    ) dut (
        .clk(clk), .resetb(resetb), .bank(bank), .addr(addr), .rnw(rnw),
        .vda(vda), .vpa(vpa), .vpb(vpb), .cpu_e(cpu_e), .wdata(wdata),
        .hs_active(hs_active), .host_ack(host_ack), .ram_ceb(ram_ceb),
        .ram_bank(ram_bank), .host_sel(host_sel), .host_req(host_req),
        .host_wr_ok(host_wr_ok), .rdy_o(rdy_o), .reg_sel(reg_sel),
        .reg_rdata(reg_rdata), .clk_cfg(clk_cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model state: readable image of the register file, plus host-stall bookkeeping.
    logic [7:0] m_reg [16];
    logic       m_sticky;
    logic [3:0] m_page;
    logic       m_busy;     // CPU currently held waiting for the host
    logic       m_rel;      // release cycle following a host wait
    int         m_waits;    // wait cycles already completed in this stall

    typedef struct packed {
        logic [7:0] eb;
        logic       reg_sel;
        logic       host_sel;
        logic       ram_ceb;
        logic       hit;
        logic       rdy;
        logic       host_req;
        logic       wr_ok;
        logic [7:0] rdata;
    } exp_t;

    exp_t ce, pe;

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
        m_reg[4] = 8'h80; m_reg[5] = 8'hFE;
        m_reg[6] = 8'h81; m_reg[7] = 8'hFE;
        m_sticky = 1'b0; m_page = 4'h0;
        m_busy = 1'b0; m_rel = 1'b0; m_waits = 0;
    endtask

    function automatic exp_t predict();
        exp_t e;
        logic found;
        e = '0;
        e.eb = bank;
        if (!vpb && !cpu_e) e.eb = 8'hFF;
        else if (bank == 8'hBF) e.reg_sel = 1'b1;
        else if (bank == 8'h00) begin
            found = 1'b0;
            for (int i = 0; i < NWIN; i++) begin
                if (!found && m_reg[4+2*i][7] && (m_reg[4+2*i][1:0] == addr[15:14])) begin
                    found = 1'b1;
                    e.eb = m_reg[5+2*i];
                end
            end
            if (!found && addr[15:14] == 2'b10 && m_reg[0][5] && m_page == m_reg[2][3:0])
                e.eb = m_reg[3];
        end
        e.ram_ceb  = !((vda | vpa) && e.eb[7:6] == 2'b11 && !e.reg_sel);
        e.host_sel = (vda | vpa) && !e.eb[7];
        e.wr_ok    = !(m_reg[0][6] && !addr[15]);
        e.hit      = e.host_sel && hs_active && m_reg[0][7];
        if (m_rel)       e.rdy = 1'b1;
        else if (m_busy) e.rdy = 1'b0;
        else             e.rdy = !e.hit;
        e.host_req = !e.rdy;
        if (e.reg_sel) e.rdata = (addr[3:0] == 4'd1) ? {7'b0, m_sticky} : m_reg[addr[3:0]];
        return e;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic       timed_out;
        logic [3:0] off;
        pe = predict();
        timed_out = 1'b0;
        if (m_rel) m_rel = 1'b0;
        else if (m_busy) begin
            if (host_ack) begin m_busy = 1'b0; m_rel = 1'b1; end
            else if (m_waits + 1 == TIMEOUT) begin m_busy = 1'b0; m_rel = 1'b1; timed_out = 1'b1; end
            else m_waits++;
        end else if (pe.hit) begin
            m_busy = 1'b1; m_waits = 0;
        end
        if (pe.reg_sel && !rnw && vda && pe.rdy) begin
            off = addr[3:0];
            if (off == 4'd0) m_reg[0] = wdata & 8'hEF;
            else if (off == 4'd1) begin if (wdata[0]) m_sticky = 1'b0; end
            else if (off == 4'd2) m_reg[2] = {4'h0, wdata[3:0]};
            else if (off == 4'd3) m_reg[3] = wdata;
            else if (int'(off) < 4 + 2 * NWIN) m_reg[off] = off[0] ? wdata : (wdata & 8'h83);
        end
        if (timed_out) m_sticky = 1'b1;
        if ((vda | vpa) && !rnw && pe.eb == 8'h00 && addr == 16'hFE30) m_page = wdata[3:0];
    endtask

    always @(negedge clk) begin
        ce = predict();
        chk("ram_ceb",    32'(ram_ceb),    32'(ce.ram_ceb));
        chk("ram_bank",   32'(ram_bank),   32'(ce.eb[2:0]));
        chk("host_sel",   32'(host_sel),   32'(ce.host_sel));
        chk("host_req",   32'(host_req),   32'(ce.host_req));
        chk("host_wr_ok", 32'(host_wr_ok), 32'(ce.wr_ok));
        chk("rdy_o",      32'(rdy_o),      32'(ce.rdy));
        chk("reg_sel",    32'(reg_sel),    32'(ce.reg_sel));
        chk("clk_cfg",    32'(clk_cfg),    32'(m_reg[0][3:0]));
        if (ce.reg_sel) chk("reg_rdata", 32'(reg_rdata), 32'(ce.rdata));
    end

    task automatic tick();
        @(posedge clk);
        if (resetb) model_step();
        #1;
    endtask

    task automatic idle();
        vda = 1'b0; vpa = 1'b0; vpb = 1'b1; cpu_e = 1'b1; rnw = 1'b1;
    endtask

    task automatic bus(input logic [7:0] b, input logic [15:0] a, input logic r, input logic [7:0] d);
        bank = b; addr = a; rnw = r; wdata = d;
        vda = 1'b1; vpa = 1'b0; vpb = 1'b1; cpu_e = 1'b1;
    endtask

    task automatic wr(input logic [7:0] b, input logic [15:0] a, input logic [7:0] d);
        bus(b, a, 1'b0, d);
        tick();
    endtask

    initial begin
        resetb = 1'b0; bank = 8'h00; addr = 16'h0000; wdata = 8'h00;
        hs_active = 1'b0; host_ack = 1'b0;
        idle();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdy", 32'(rdy_o), 32'd1);
        chk("reset_req", 32'(host_req), 32'd0);
        chk("reset_clkcfg", 32'(clk_cfg), 32'd0);
        @(negedge clk); #1; resetb = 1'b1;
        tick();

        // Boot map: region 0 of bank 0 lands in RAM bank FE, region 2 goes to the host.
        bus(8'h00, 16'h4123, 1'b1, 8'h00); #1;
        chk("boot_ceb", 32'(ram_ceb), 32'd0);
        chk("boot_bank", 32'(ram_bank), 32'd6);
        tick();
        bus(8'h00, 16'h8000, 1'b1, 8'h00); #1;
        chk("boot_host", 32'(host_sel), 32'd1);
        tick();

        wr(8'hBF, 16'h0008, 8'h82); wr(8'hBF, 16'h0009, 8'hC5);
        wr(8'hBF, 16'h000A, 8'h82); wr(8'hBF, 16'h000B, 8'hC7);
        bus(8'h00, 16'h9000, 1'b1, 8'h00); #1;
        chk("win_prio_bank", 32'(ram_bank), 32'd5);
        chk("win_prio_ceb", 32'(ram_ceb), 32'd0);
        tick();
        bus(8'hBF, 16'h0008, 1'b1, 8'h00); #1;
        chk("win2_readback", 32'(reg_rdata), 32'h82);
        chk("regsel", 32'(reg_sel), 32'd1);
        tick();
        wr(8'hBF, 16'h000C, 8'h55);
        bus(8'hBF, 16'h000C, 1'b1, 8'h00); #1;
        chk("unmapped_rd", 32'(reg_rdata), 32'h00);
        tick();
        wr(8'hBF, 16'h0008, 8'h00);
        bus(8'h00, 16'h9000, 1'b1, 8'h00); #1;
        chk("win3_after_win2_off", 32'(ram_bank), 32'd7);
        tick();
        wr(8'hBF, 16'h000A, 8'h00);

        // Paged-ROM shadow: slot 7 maps into bank C3 only while the latch holds 7.
        wr(8'h00, 16'hFE30, 8'h07);
        wr(8'hBF, 16'h0002, 8'h07);
        wr(8'hBF, 16'h0003, 8'hC3);
        wr(8'hBF, 16'h0000, 8'h6A);
        bus(8'h00, 16'hA000, 1'b1, 8'h00); #1;
        chk("rom_bank", 32'(ram_bank), 32'd3);
        chk("rom_ceb", 32'(ram_ceb), 32'd0);
        chk("rom_clkcfg", 32'(clk_cfg), 32'hA);
        tick();
        bus(8'h00, 16'h1000, 1'b1, 8'h00); #1;
        chk("wr_blocked", 32'(host_wr_ok), 32'd0);
        tick();
        wr(8'h00, 16'hFE30, 8'h02);
        bus(8'h00, 16'hA000, 1'b1, 8'h00); #1;
        chk("rom_miss_host", 32'(host_sel), 32'd1);
        chk("rom_miss_wrok", 32'(host_wr_ok), 32'd1);
        tick();

        // Native-mode vector pull redirects to bank FF; emulation mode does not.
        bus(8'h00, 16'hFFEA, 1'b1, 8'h00); vpb = 1'b0; cpu_e = 1'b0; #1;
        chk("vec_ceb", 32'(ram_ceb), 32'd0);
        chk("vec_bank", 32'(ram_bank), 32'd7);
        cpu_e = 1'b1; #1;
        chk("vec_emul_host", 32'(host_sel), 32'd1);
        tick();

        // Host wait with acknowledge on the third wait cycle.
        wr(8'hBF, 16'h0000, 8'h80);
        hs_active = 1'b1;
        bus(8'h00, 16'h8000, 1'b1, 8'h00); #1;
        chk("wait_rdy_same_cycle", 32'(rdy_o), 32'd0);
        chk("wait_req_same_cycle", 32'(host_req), 32'd1);
        tick(); tick(); tick();
        host_ack = 1'b1; #1;
        chk("wait3_rdy", 32'(rdy_o), 32'd0);
        tick();
        host_ack = 1'b0; #1;
        chk("done_rdy", 32'(rdy_o), 32'd1);
        chk("done_req", 32'(host_req), 32'd0);
        idle(); tick();
        bus(8'hBF, 16'h0001, 1'b1, 8'h00); #1;
        chk("ack_status", 32'(reg_rdata), 32'd0);
        tick();

        // Host wait with no acknowledge: forced release after TIMEOUT wait cycles.
        bus(8'h00, 16'h8000, 1'b1, 8'h00); #1;
        chk("to_rdy_start", 32'(rdy_o), 32'd0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick(); #1;
            chk("to_rdy_wait", 32'(rdy_o), 32'd0);
        end
        tick(); #1;
        chk("to_release", 32'(rdy_o), 32'd1);
        idle(); tick();
        bus(8'hBF, 16'h0001, 1'b1, 8'h00); #1;
        chk("to_status_set", 32'(reg_rdata), 32'd1);
        tick();
        wr(8'hBF, 16'h0001, 8'h01);
        bus(8'hBF, 16'h0001, 1'b1, 8'h00); #1;
        chk("to_status_clr", 32'(reg_rdata), 32'd0);
        tick();

        // Asynchronous reset in the middle of a wait.
        bus(8'h00, 16'h8000, 1'b1, 8'h00);
        tick(); tick(); #1;
        chk("pre_reset_rdy", 32'(rdy_o), 32'd0);
        resetb = 1'b0; m_reset(); #1;
        chk("async_reset_rdy", 32'(rdy_o), 32'd1);
        chk("async_reset_req", 32'(host_req), 32'd0);
        @(negedge clk); #1; resetb = 1'b1;
        idle(); tick();

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 35) bank = 8'h00;
            else if (r < 60) bank = 8'hBF;
            else bank = 8'($urandom);
            addr = 16'($urandom);
            if ($urandom_range(0, 9) == 0) addr = 16'hFE30;
            rnw       = ($urandom_range(0, 1) == 1);
            vda       = ($urandom_range(0, 3) != 0);
            vpa       = ($urandom_range(0, 3) == 0);
            vpb       = ($urandom_range(0, 9) != 0);
            cpu_e     = ($urandom_range(0, 1) == 1);
            wdata     = 8'($urandom);
            hs_active = ($urandom_range(0, 3) != 0);
            host_ack  = ($urandom_range(0, 7) == 0);
            tick();
        end

        idle(); host_ack = 1'b0; hs_active = 1'b0;
        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
